// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, icache request and F/D latch.
// Fetching stops for good once a HALT instruction is written into F/D; only RST leaves that state.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'h3F,
    parameter int          CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pc_wen,
    input  logic [1:0]       pcsrc,
    input  logic [31:0]      branch_addr,
    input  logic [31:0]      jump_addr,
    input  logic [31:0]      jr_addr,
    input  logic [1:0]       fd_state,
    input  logic             ihit,
    input  logic [31:0]      iload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    output logic [31:0]      fd_instr,
    output logic [31:0]      fd_npc,
    output logic             fd_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             dbg_state
);

    // F/D latch command encoding shared with the hazard unit.
    localparam logic [1:0] PIPE_ENABLE = 2'd0;
    localparam logic [1:0] PIPE_STALL  = 2'd1;
    localparam logic [1:0] PIPE_NOP    = 2'd2;

    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_mux;
    logic        load_fd;
    logic        flush_fd;

    // Icache handshake: iREN is the request, ihit qualifies iload in the same cycle.
    // A request without ihit is a miss and simply repeats next cycle at the same address.
    assign iREN      = (state == FETCH);
    assign iaddr     = pc;
    assign halted    = (state == HALTED);
    assign dbg_state = state;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        pc_mux = pc_plus4;
        case (pcsrc)
            2'd1:    pc_mux = branch_addr;
            2'd2:    pc_mux = jump_addr;
            2'd3:    pc_mux = jr_addr;
            default: pc_mux = pc_plus4;
        endcase
    end

    // STALL and the unused encoding fall through to "hold".
    always_comb begin
        flush_fd   = 1'b0;
        load_fd    = 1'b0;
        state_next = state;
        if (state == FETCH) begin
            if (fd_state == PIPE_NOP) begin
                flush_fd = 1'b1;
            end else if (fd_state == PIPE_ENABLE && ihit) begin
                load_fd = 1'b1;
                if (iload[31:26] == HALT_OP) begin
                    state_next = HALTED;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc        <= PC_INIT;
            fd_instr  <= 32'd0;
            fd_npc    <= 32'd0;
            fd_valid  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (state == FETCH && pc_wen) begin
                pc <= pc_mux;
            end
            if (flush_fd) begin
                fd_instr <= 32'd0;
                fd_npc   <= 32'd0;
                fd_valid <= 1'b0;
            end else if (load_fd) begin
                fd_instr <= iload;
                fd_npc   <= pc_plus4;
                fd_valid <= 1'b1;
                if (fetch_cnt != {CNT_W{1'b1}}) begin
                    fetch_cnt <= fetch_cnt + 1'b1;
                end
            end
        end
    end

endmodule
